ysyx_23060187_inst_fetch: RTL and testbench
===========================================

YSYX_23060187_INST_FETCH -- requirements
Module: ysyx_23060187_inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h8000_0000, PC value loaded at reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: imem_req_valid  output  1  fetch request valid.
REQ-005 Port: imem_req_ready  input  1  memory accepts request.
REQ-006 Port: imem_addr  output  32  fetch address; always equals pc.
REQ-007 Port: imem_rsp_valid  input  1  read data valid.
REQ-008 Port: imem_rsp_data  input  32  fetched instruction word.
REQ-009 Port: redirect_valid  input  1  PC redirect from branch/jump unit.
REQ-010 Port: redirect_pc  input  32  redirect target.
REQ-011 Port: inst_valid  output  1  instruction available to decode.
REQ-012 Port: inst_ready  input  1  decode accepts instruction.
REQ-013 Port: inst  output  32  registered instruction word, drives decode inst input.
REQ-014 Port: inst_pc  output  32  PC of the word on inst.

Function
REQ-015 The block SHALL implement states IDLE, REQ, WAIT, HOLD, with at most one outstanding memory request.
REQ-016 imem_req_valid SHALL be 1 only in REQ; inst_valid SHALL be 1 only in HOLD; both are state decodes with no combinational path from inputs.
REQ-017 IDLE SHALL go to REQ unconditionally on the first edge after reset release.
REQ-018 REQ SHALL go to WAIT on imem_req_valid & imem_req_ready; otherwise it SHALL remain in REQ.
REQ-019 WAIT SHALL, on imem_rsp_valid, capture imem_rsp_data into inst and pc into inst_pc, then go to HOLD; inst_valid rises the cycle after imem_rsp_valid.
REQ-020 HOLD SHALL keep inst and inst_pc stable until inst_valid & inst_ready, then set pc <= pc + 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0) and go to REQ.
REQ-021 Minimum latency SHALL be: request accepted cycle N, response N+1, inst_valid N+2, next request N+3 if inst_ready held high.
REQ-022 redirect_valid SHALL set pc <= {redirect_pc[31:2], 2'b00} on that edge in every non-IDLE state; bits [1:0] are ignored.
REQ-023 Redirect in REQ without handshake: stay in REQ, next request uses new pc.
REQ-024 Redirect in REQ with handshake the same cycle: go to WAIT with drop flag set.
REQ-025 Redirect in WAIT: set drop flag; a response received with drop set (including the same cycle as the redirect) SHALL be discarded, clear drop, and go to REQ without asserting inst_valid.
REQ-026 Redirect in HOLD: go to REQ and deassert inst_valid next cycle; if inst_ready is also high that cycle, the word counts as consumed, but pc takes redirect_pc, not pc + 4.
REQ-027 Redirect SHALL have priority over the pc + 4 increment in all states.
REQ-028 imem_rsp_valid in IDLE, REQ or HOLD SHALL be ignored.

Reset
REQ-029 On rst assertion, asynchronously and without waiting for clk: state=IDLE, pc=RESET_PC, drop=0, inst=32'h0000_0013 (nop), inst_pc=RESET_PC.
REQ-030 During reset: imem_req_valid=0, inst_valid=0, imem_addr=RESET_PC.
REQ-031 Reset asserted mid-transaction (WAIT or HOLD) SHALL abandon the transaction; a late response after reset release SHALL be ignored per REQ-028.

Verification
REQ-032 Reset release, imem_req_ready=1, 1-cycle memory returning 32'h0000_0297, inst_ready=1 -> inst=32'h0000_0297, inst_pc=32'h8000_0000 two cycles after request; next imem_addr=32'h8000_0004.
REQ-033 inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable, imem_req_valid=0 throughout; no pc change.
REQ-034 redirect_valid with redirect_pc=32'h8000_0102 while in WAIT -> pending response discarded, no inst_valid, next imem_addr=32'h8000_0100.
REQ-035 redirect_valid and inst_ready both high in HOLD with pc=32'h8000_0010, redirect_pc=32'h8000_0040 -> next imem_addr=32'h8000_0040, not 32'h8000_0014.
REQ-036 pc=32'hFFFF_FFFC consumed -> next imem_addr=32'h0000_0000.
REQ-037 rst pulsed asynchronously between clock edges while in HOLD -> inst_valid=0 immediately; after release, first request address is 32'h8000_0000.

Source files
------------

// File: rtl/ysyx_23060187_inst_fetch.sv
// Instruction fetch unit: keeps at most one memory request in flight, holds the
// fetched word for decode, and follows PC redirects from the branch/jump unit.
module ysyx_23060187_inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic [31:0] redirect_target;

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Handshake outputs are pure decodes of the state register.
  assign imem_req_valid = (state == REQ);
  assign inst_valid     = (state == HOLD);
  assign imem_addr      = pc;

  // Fetch FSM: sequencing, PC update (redirect beats +4), stale-response drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      inst    <= NOP;
      inst_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (redirect_valid) pc <= redirect_target;
          if (imem_req_ready) begin
            state <= WAIT;
            // Request already issued for the old pc; its response is stale.
            drop  <= redirect_valid;
          end
        end
        WAIT: begin
          if (redirect_valid) pc <= redirect_target;
          if (imem_rsp_valid) begin
            if (drop || redirect_valid) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              inst    <= imem_rsp_data;
              inst_pc <= pc;
              state   <= HOLD;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_target;
            state <= REQ;
          end else if (inst_ready) begin
            pc    <= pc + 32'd4;
            state <= REQ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_inst_fetch.sv
// Directed self-checking bench for ysyx_23060187_inst_fetch.
module tb_ysyx_23060187_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int unsigned total;
  int unsigned bad;

  ysyx_23060187_inst_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    step();
    step();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h8000_0000);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'h8000_0000);
    #2 rst = 1'b0;

    // IDLE -> REQ
    step();
    check("idle_to_req", {31'd0, imem_req_valid}, 32'd1);
    check("first_addr", imem_addr, 32'h8000_0000);

    // Request accepted, 1-cycle response
    imem_req_ready = 1'b1;
    step();
    check("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0297;
    step();
    imem_rsp_valid = 1'b0;
    check("hold_valid", {31'd0, inst_valid}, 32'd1);
    check("hold_inst", inst, 32'h0000_0297);
    check("hold_inst_pc", inst_pc, 32'h8000_0000);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_inst", inst, 32'h0000_0297);
      check("stall_inst_pc", inst_pc, 32'h8000_0000);
      check("stall_req", {31'd0, imem_req_valid}, 32'd0);
      check("stall_addr", imem_addr, 32'h8000_0000);
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
    end

    // Consume -> next request at pc+4
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("next_req", {31'd0, imem_req_valid}, 32'd1);
    check("next_addr", imem_addr, 32'h8000_0004);
    check("next_no_inst", {31'd0, inst_valid}, 32'd0);

    // Redirect in WAIT discards pending response
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    check("wait_redir_no_inst", {31'd0, inst_valid}, 32'd0);
    check("wait_redir_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    check("drop_no_inst", {31'd0, inst_valid}, 32'd0);
    check("drop_req", {31'd0, imem_req_valid}, 32'd1);
    check("drop_addr", imem_addr, 32'h8000_0100);
    check("drop_inst_kept", inst, 32'h0000_0297);

    // Redirect in REQ without handshake
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0010;
    step();
    redirect_valid = 1'b0;
    check("req_redir_req", {31'd0, imem_req_valid}, 32'd1);
    check("req_redir_addr", imem_addr, 32'h8000_0010);

    // Fetch at 0x8000_0010, then redirect + inst_ready in HOLD
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    step();
    imem_rsp_valid = 1'b0;
    check("hold2_inst", inst, 32'h0010_0093);
    check("hold2_inst_pc", inst_pc, 32'h8000_0010);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    inst_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    check("hold_redir_addr", imem_addr, 32'h8000_0040);
    check("hold_redir_no_inst", {31'd0, inst_valid}, 32'd0);
    check("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);

    // Redirect in REQ with handshake; low bits ignored
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    check("hs_redir_addr", imem_addr, 32'hFFFF_FFFC);
    check("hs_redir_wait", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    step();
    imem_rsp_valid = 1'b0;
    check("hs_drop_no_inst", {31'd0, inst_valid}, 32'd0);
    check("hs_drop_req", {31'd0, imem_req_valid}, 32'd1);

    // Fetch at 0xFFFF_FFFC and wrap
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_ABCD;
    step();
    imem_rsp_valid = 1'b0;
    check("top_inst", inst, 32'h0000_ABCD);
    check("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Response in REQ is ignored
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_2222;
    step();
    imem_rsp_valid = 1'b0;
    check("req_rsp_ignored_req", {31'd0, imem_req_valid}, 32'd1);
    check("req_rsp_ignored_inst", {31'd0, inst_valid}, 32'd0);

    // Redirect in WAIT in the same cycle as the response
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h3333_3333;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    check("same_cyc_no_inst", {31'd0, inst_valid}, 32'd0);
    check("same_cyc_addr", imem_addr, 32'h8000_0200);
    check("same_cyc_inst_kept", inst, 32'h0000_ABCD);

    // Async reset while in HOLD
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_1234;
    step();
    imem_rsp_valid = 1'b0;
    check("pre_rst_hold", {31'd0, inst_valid}, 32'd1);
    check("pre_rst_inst_pc", inst_pc, 32'h8000_0200);
    #2 rst = 1'b1;
    #1;
    check("async_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("async_rst_addr", imem_addr, 32'h8000_0000);
    check("async_rst_inst", inst, 32'h0000_0013);
    #1 rst = 1'b0;
    // Late response after reset release
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h4444_4444;
    step();
    check("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h8000_0000);
    check("post_rst_no_inst", {31'd0, inst_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b0;
    check("late_rsp_ignored", {31'd0, inst_valid}, 32'd0);
    check("late_rsp_inst", inst, 32'h0000_0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
